push_key_reader: RTL

- Input-side counterpart of the board's display/LED output path: turns the 4 raw push-button pins into clean, debounced key levels and one-cycle events.
- Adds auto-repeat and a single-entry event register with a valid/ack handshake.
- Sits between the PUSH0..PUSH3 pins and consumers such as PwmCtrl or a Nios PIO.

---
 rtl/push_key_pkg.sv | 27 ++
 rtl/push_key_channel.sv | 149 ++++++++++++++
 rtl/push_key_reader.sv | 111 +++++++++++
 3 files changed

// File: rtl/push_key_pkg.sv
// rtl/push_key_pkg.sv - shared encodings and width helper for the push-button reader
package push_key_pkg;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_RELEASE = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DEB_DN = 2'd1,
        ST_HELD   = 2'd2,
        ST_DEB_UP = 2'd3
    } chan_state_t;

    // Bits needed to hold values 0..value (at least 1).
    function automatic int cnt_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) <= value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/push_key_channel.sv
// rtl/push_key_channel.sv - one button: synchronizer, debounce FSM and auto-repeat
module push_key_channel
    import push_key_pkg::*;
#(
    parameter int ACTIVE_LOW   = 1,
    parameter int DEB_TICKS    = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic tick,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DW = cnt_width(DEB_TICKS);
    localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
    localparam logic [DW-1:0] DEB_C   = DW'(DEB_TICKS);
    localparam logic [RW-1:0] DELAY_C = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_C  = RW'(REPEAT_RATE);
    localparam logic RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam bit DEB_ONE    = (DEB_TICKS == 1);
    localparam bit REP_EN     = (REPEAT_DELAY != 0);

    logic [1:0]    sync_q;
    logic          pressed_s;
    chan_state_t   state, state_next;
    logic [DW-1:0] dcnt, dcnt_next, dcnt_inc;
    logic [RW-1:0] rcnt, rcnt_next, rcnt_inc, rep_target;
    logic          rep_started, rep_started_next;
    logic          level_next, press_next, release_next, repeat_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {2{RELEASED}};
        end else begin
            sync_q <= {sync_q[0], pin};
        end
    end

    assign pressed_s  = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];
    assign dcnt_inc   = dcnt + DW'(1);
    assign rcnt_inc   = rcnt + RW'(1);
    assign rep_target = rep_started ? RATE_C : DELAY_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            dcnt          <= '0;
            rcnt          <= '0;
            rep_started   <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_next;
            dcnt          <= dcnt_next;
            rcnt          <= rcnt_next;
            rep_started   <= rep_started_next;
            level         <= level_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            repeat_pulse  <= repeat_next;
        end
    end

    always_comb begin
        state_next       = state;
        dcnt_next        = dcnt;
        rcnt_next        = rcnt;
        rep_started_next = rep_started;
        level_next       = level;
        press_next       = 1'b0;
        release_next     = 1'b0;
        repeat_next      = 1'b0;
        if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (pressed_s) begin
                        if (DEB_ONE) begin
                            state_next       = ST_HELD;
                            level_next       = 1'b1;
                            press_next       = 1'b1;
                            rcnt_next        = '0;
                            rep_started_next = 1'b0;
                        end else begin
                            state_next = ST_DEB_DN;
                            dcnt_next  = DW'(1);
                        end
                    end
                end
                ST_DEB_DN: begin
                    if (!pressed_s) begin
                        state_next = ST_IDLE;
                        dcnt_next  = '0;
                    end else if (dcnt_inc == DEB_C) begin
                        state_next       = ST_HELD;
                        dcnt_next        = '0;
                        level_next       = 1'b1;
                        press_next       = 1'b1;
                        rcnt_next        = '0;
                        rep_started_next = 1'b0;
                    end else begin
                        dcnt_next = dcnt_inc;
                    end
                end
                ST_HELD: begin
                    if (pressed_s) begin
                        // After the first repeat the target switches to the shorter rate.
                        if (REP_EN && (rcnt_inc == rep_target)) begin
                            repeat_next      = 1'b1;
                            rcnt_next        = '0;
                            rep_started_next = 1'b1;
                        end else if (rcnt != {RW{1'b1}}) begin
                            rcnt_next = rcnt_inc;
                        end
                    end else if (DEB_ONE) begin
                        state_next   = ST_IDLE;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        state_next = ST_DEB_UP;
                        dcnt_next  = DW'(1);
                    end
                end
                ST_DEB_UP: begin
                    if (pressed_s) begin
                        state_next = ST_HELD;
                        dcnt_next  = '0;
                    end else if (dcnt_inc == DEB_C) begin
                        state_next   = ST_IDLE;
                        dcnt_next    = '0;
                        level_next   = 1'b0;
                        release_next = 1'b1;
                    end else begin
                        dcnt_next = dcnt_inc;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/push_key_reader.sv
// rtl/push_key_reader.sv - debounced push-button reader with shared tick and event register
module push_key_reader
    import push_key_pkg::*;
#(
    parameter int N_KEYS       = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int TICK_DIV     = 50000,
    parameter int DEB_TICKS    = 20,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [N_KEYS-1:0] PUSH,
    output logic [N_KEYS-1:0] KEY_LEVEL,
    output logic [N_KEYS-1:0] KEY_PRESS,
    output logic [N_KEYS-1:0] KEY_RELEASE,
    output logic [N_KEYS-1:0] KEY_REPEAT,
    output logic              EVT_VALID,
    output logic [1:0]        EVT_KEY,
    output logic [1:0]        EVT_TYPE,
    input  logic              EVT_ACK,
    output logic              EVT_OVF
);

    localparam int TW = cnt_width(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    logic [3*N_KEYS-1:0]   all_pulses;
    logic                  any_evt, multi_evt, found;
    logic [1:0]            sel_key, sel_type;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        push_key_channel #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DEB_TICKS    (DEB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_chan (
            .clk           (CLK),
            .rst           (RST),
            .pin           (PUSH[g]),
            .tick          (tick),
            .level         (KEY_LEVEL[g]),
            .press_pulse   (KEY_PRESS[g]),
            .release_pulse (KEY_RELEASE[g]),
            .repeat_pulse  (KEY_REPEAT[g])
        );
    end

    // More than one bit set anywhere means at least one event cannot be held.
    assign all_pulses = {KEY_REPEAT, KEY_RELEASE, KEY_PRESS};
    assign any_evt    = |all_pulses;
    assign multi_evt  = |(all_pulses & (all_pulses - (3*N_KEYS)'(1)));

    always_comb begin
        found    = 1'b0;
        sel_key  = '0;
        sel_type = EVT_PRESS;
        for (int i = 0; i < N_KEYS; i++) begin
            if (!found && (KEY_PRESS[i] || KEY_RELEASE[i] || KEY_REPEAT[i])) begin
                found   = 1'b1;
                sel_key = 2'(i);
                if (KEY_PRESS[i]) begin
                    sel_type = EVT_PRESS;
                end else if (KEY_RELEASE[i]) begin
                    sel_type = EVT_RELEASE;
                end else begin
                    sel_type = EVT_REPEAT;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EVT_VALID <= 1'b0;
            EVT_KEY   <= '0;
            EVT_TYPE  <= '0;
            EVT_OVF   <= 1'b0;
        end else begin
            if (!EVT_VALID || EVT_ACK) begin
                if (any_evt) begin
                    EVT_VALID <= 1'b1;
                    EVT_KEY   <= sel_key;
                    EVT_TYPE  <= sel_type;
                end else begin
                    EVT_VALID <= 1'b0;
                end
            end
            if (multi_evt || (any_evt && EVT_VALID && !EVT_ACK)) begin
                EVT_OVF <= 1'b1;
            end
        end
    end

endmodule
